// File: rtl/fft_seq.sv
// Radix-2 in-place FFT butterfly sequencer: walks stages and butterflies,
// issuing operand addresses and twiddle indices, with a drain gap after each stage.
module fft_seq #(
  parameter int N_LOG2 = 3,
  parameter int BF_LAT = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        stall,
  output logic                        busy,
  output logic                        done,
  output logic                        bf_valid,
  output logic [N_LOG2-1:0]           addr_a,
  output logic [N_LOG2-1:0]           addr_b,
  output logic [N_LOG2-2:0]           tw_idx,
  output logic [$clog2(N_LOG2)-1:0]   stage
);

  // state | meaning
  // IDLE  | waiting for start
  // ISSUE | one butterfly per non-stalled cycle, k ascending
  // GAP   | BF_LAT-cycle drain between stages
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, ISSUE, GAP, DONE} state_t;

  localparam int KW = N_LOG2 - 1;
  localparam int SW = $clog2(N_LOG2);
  localparam logic [KW-1:0] K_LAST   = {KW{1'b1}};
  localparam logic [SW-1:0] S_LAST   = SW'(N_LOG2 - 1);
  localparam logic [2:0]    GAP_LOAD = 3'(BF_LAT - 1);

  state_t          state, state_nx;
  logic [KW-1:0]   k, k_nx;
  logic [SW-1:0]   s, s_nx;
  logic [2:0]      gap_cnt, gap_nx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      k       <= '0;
      s       <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_nx;
      k       <= k_nx;
      s       <= s_nx;
      gap_cnt <= gap_nx;
    end
  end

  always_comb begin
    state_nx = state;
    k_nx     = k;
    s_nx     = s;
    gap_nx   = gap_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = ISSUE;
          k_nx     = '0;
          s_nx     = '0;
        end
      end
      ISSUE: begin
        if (!stall) begin
          if (k == K_LAST) begin
            state_nx = GAP;
            k_nx     = '0;
            gap_nx   = GAP_LOAD;
          end else begin
            k_nx = k + KW'(1);
          end
        end
      end
      GAP: begin
        if (!stall) begin
          if (gap_cnt == 3'd0) begin
            if (s == S_LAST) begin
              state_nx = DONE;
            end else begin
              state_nx = ISSUE;
              s_nx     = s + SW'(1);
            end
          end else begin
            gap_nx = gap_cnt - 3'd1;
          end
        end
      end
      DONE: begin
        if (!stall) begin
          state_nx = IDLE;
          s_nx     = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Addresses: clear bit s of k's position by shifting the group index up one place
  logic [N_LOG2-1:0] k_ext, span, pos, a_calc, tw_full;

  always_comb begin
    k_ext   = N_LOG2'(k);
    span    = N_LOG2'(1) << s;
    pos     = k_ext & (span - N_LOG2'(1));
    a_calc  = (((k_ext >> s) << s) << 1) | pos;
    tw_full = pos << (S_LAST - s);
  end

  // Outputs are gated by rst_n so they read zero while reset is held
  always_comb begin
    bf_valid = rst_n && (state == ISSUE);
    busy     = rst_n && ((state == ISSUE) || (state == GAP));
    done     = rst_n && (state == DONE);
    addr_a   = bf_valid ? a_calc : '0;
    addr_b   = bf_valid ? (a_calc | span) : '0;
    tw_idx   = bf_valid ? tw_full[N_LOG2-2:0] : '0;
    stage    = busy ? s : '0;
  end

endmodule

// File: tb/tb_fft_seq.sv
// Bench for fft_seq: an event-queue model of the transform schedule predicts every
// cycle's outputs; literal expectations pin the model and the DUT at key cycles.
module tb_fft_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, stall;

  logic       busy0, done0, v0;
  logic [2:0] a0, b0;
  logic [1:0] tw0, st0;

  logic       busy1, done1, v1;
  logic [3:0] a1, b1;
  logic [2:0] tw1;
  logic [1:0] st1;

  fft_seq u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .busy(busy0), .done(done0), .bf_valid(v0),
    .addr_a(a0), .addr_b(b0), .tw_idx(tw0), .stage(st0)
  );

  fft_seq #(.N_LOG2(4), .BF_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .busy(busy1), .done(done1), .bf_valid(v1),
    .addr_a(a1), .addr_b(b1), .tw_idx(tw1), .stage(st1)
  );

  localparam int MAXC = 64;
  localparam int OFF  = 2;

  typedef struct {int kind; int a; int b; int tw; int stg;} ev_t;

  bit in_start[MAXC], in_stall[MAXC], in_rstn[MAXC];
  int e_v[MAXC], e_a[MAXC], e_b[MAXC], e_tw[MAXC], e_busy[MAXC], e_done[MAXC], e_stg[MAXC], e_kind[MAXC];
  int g_v[MAXC], g_a[MAXC], g_b[MAXC], g_tw[MAXC], g_busy[MAXC], g_done[MAXC], g_stg[MAXC];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic clear_in();
    for (int t = 0; t < MAXC; t++) begin
      in_rstn[t]  = (t >= OFF);
      in_start[t] = 1'b0;
      in_stall[t] = 1'b0;
    end
  endtask

  // kind: 0 idle, 1 issue, 2 gap, 3 done
  function automatic void build(input int nl, input int bl, input int len);
    ev_t q[$];
    ev_t e;
    int  span, pos, grp;
    for (int t = 0; t < len; t++) begin
      e_v[t] = 0; e_a[t] = 0; e_b[t] = 0; e_tw[t] = 0;
      e_busy[t] = 0; e_done[t] = 0; e_stg[t] = 0; e_kind[t] = 0;
      if (in_rstn[t] && q.size() > 0) begin
        e = q[0];
        e_kind[t] = e.kind;
        e_v[t]    = (e.kind == 1);
        e_a[t]    = e.a;
        e_b[t]    = e.b;
        e_tw[t]   = e.tw;
        e_busy[t] = (e.kind != 3);
        e_done[t] = (e.kind == 3);
        e_stg[t]  = e.stg;
      end
      if (!in_rstn[t]) begin
        q.delete();
      end else if (q.size() == 0) begin
        if (in_start[t]) begin
          for (int s = 0; s < nl; s++) begin
            span = 1 << s;
            for (int k = 0; k < (1 << (nl - 1)); k++) begin
              pos = k % span;
              grp = k / span;
              e.kind = 1; e.stg = s;
              e.a  = grp * 2 * span + pos;
              e.b  = e.a + span;
              e.tw = pos << (nl - 1 - s);
              q.push_back(e);
            end
            for (int g = 0; g < bl; g++) begin
              e.kind = 2; e.a = 0; e.b = 0; e.tw = 0; e.stg = s;
              q.push_back(e);
            end
          end
          e.kind = 3; e.a = 0; e.b = 0; e.tw = 0; e.stg = 0;
          q.push_back(e);
        end
      end else if (!in_stall[t]) begin
        void'(q.pop_front());
      end
    end
  endfunction

  task automatic run(input int sel, input int nl, input int bl, input int len, input string tn);
    build(nl, bl, len);
    for (int t = 0; t < len; t++) begin
      rst_n = in_rstn[t];
      start = in_start[t];
      stall = in_stall[t];
      @(negedge clk);
      if (sel == 0) begin
        g_v[t] = v0; g_a[t] = a0; g_b[t] = b0; g_tw[t] = tw0;
        g_busy[t] = busy0; g_done[t] = done0; g_stg[t] = st0;
      end else begin
        g_v[t] = v1; g_a[t] = a1; g_b[t] = b1; g_tw[t] = tw1;
        g_busy[t] = busy1; g_done[t] = done1; g_stg[t] = st1;
      end
      chk($sformatf("%s c%0d bf_valid", tn, t), g_v[t], e_v[t]);
      chk($sformatf("%s c%0d addr_a", tn, t), g_a[t], e_a[t]);
      chk($sformatf("%s c%0d addr_b", tn, t), g_b[t], e_b[t]);
      chk($sformatf("%s c%0d tw_idx", tn, t), g_tw[t], e_tw[t]);
      chk($sformatf("%s c%0d busy", tn, t), g_busy[t], e_busy[t]);
      chk($sformatf("%s c%0d done", tn, t), g_done[t], e_done[t]);
      if (e_kind[t] != 3)
        chk($sformatf("%s c%0d stage", tn, t), g_stg[t], e_stg[t]);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pin_iss(input string nm, input int t, input int a, input int b, input int tw);
    chk({nm, " model valid"}, e_v[t], 1);
    chk({nm, " model a"}, e_a[t], a);
    chk({nm, " model b"}, e_b[t], b);
    chk({nm, " model tw"}, e_tw[t], tw);
    chk({nm, " dut valid"}, g_v[t], 1);
    chk({nm, " dut a"}, g_a[t], a);
    chk({nm, " dut b"}, g_b[t], b);
    chk({nm, " dut tw"}, g_tw[t], tw);
  endtask

  task automatic pin_done(input string nm, input int t, input int len);
    int nm_cnt, nd_cnt;
    nm_cnt = 0; nd_cnt = 0;
    for (int i = 0; i < len; i++) begin
      nm_cnt += e_done[i];
      nd_cnt += g_done[i];
    end
    chk({nm, " model done at"}, e_done[t], 1);
    chk({nm, " dut done at"}, g_done[t], 1);
    chk({nm, " model done count"}, nm_cnt, 1);
    chk({nm, " dut done count"}, nd_cnt, 1);
  endtask

  function automatic int count_valid(input int len);
    int c = 0;
    for (int i = 0; i < len; i++) c += g_v[i];
    return c;
  endfunction

  int tr_a[12]  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int tr_b[12]  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int tr_tw[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  initial begin
    int n, last;
    rst_n = 1'b0; start = 1'b0; stall = 1'b0;
    @(posedge clk);
    #1;

    // Basic transform at defaults
    clear_in();
    in_stall[0] = 1'b1;
    in_start[0] = 1'b1;
    in_start[OFF] = 1'b1;
    run(0, 3, 2, OFF + 22, "basic");
    chk("basic reset busy", g_busy[0], 0);
    chk("basic reset valid", g_v[0], 0);
    pin_iss("basic c1", OFF + 1, 0, 1, 0);
    pin_iss("basic c8", OFF + 8, 1, 3, 2);
    pin_iss("basic c16", OFF + 16, 3, 7, 3);
    pin_done("basic", OFF + 19, OFF + 22);
    chk("basic busy c18", g_busy[OFF + 18], 1);
    chk("basic busy c19", g_busy[OFF + 19], 0);
    chk("basic gap c5", g_v[OFF + 5], 0);
    n = 0;
    for (int t = 0; t < OFF + 22; t++) begin
      if (g_v[t] == 1) begin
        if (n < 12) begin
          chk($sformatf("trace %0d a", n), g_a[t], tr_a[n]);
          chk($sformatf("trace %0d b", n), g_b[t], tr_b[n]);
          chk($sformatf("trace %0d tw", n), g_tw[t], tr_tw[n]);
        end
        n++;
      end
    end
    chk("trace issue count", n, 12);

    // Stall mid-stage
    clear_in();
    in_start[OFF] = 1'b1;
    for (int t = OFF + 2; t <= OFF + 4; t++) in_stall[t] = 1'b1;
    run(0, 3, 2, OFF + 25, "stall");
    pin_iss("stall c2", OFF + 2, 2, 3, 0);
    pin_iss("stall c5", OFF + 5, 2, 3, 0);
    pin_iss("stall c19", OFF + 19, 3, 7, 3);
    pin_done("stall", OFF + 22, OFF + 25);

    // Reset mid-transform then restart
    clear_in();
    in_start[OFF] = 1'b1;
    in_rstn[OFF + 9] = 1'b0;
    in_start[OFF + 12] = 1'b1;
    run(0, 3, 2, OFF + 34, "rst");
    chk("rst c10 valid", g_v[OFF + 10], 0);
    chk("rst c10 busy", g_busy[OFF + 10], 0);
    chk("rst c10 addr_b", g_b[OFF + 10], 0);
    chk("rst c9 valid", g_v[OFF + 9], 0);
    pin_iss("rst restart c8", OFF + 20, 1, 3, 2);
    pin_done("rst", OFF + 31, OFF + 34);

    // Start re-pulsed while busy
    clear_in();
    in_start[OFF] = 1'b1;
    in_start[OFF + 5] = 1'b1;
    in_start[OFF + 12] = 1'b1;
    run(0, 3, 2, OFF + 22, "repulse");
    pin_iss("repulse c16", OFF + 16, 3, 7, 3);
    pin_done("repulse", OFF + 19, OFF + 22);
    chk("repulse issue count", count_valid(OFF + 22), 12);

    // Start held high, stall with start in IDLE
    clear_in();
    for (int t = OFF; t < OFF + 24; t++) in_start[t] = 1'b1;
    in_stall[OFF] = 1'b1;
    in_stall[OFF + 1] = 1'b1;
    run(0, 3, 2, OFF + 24, "held");
    pin_iss("held c1", OFF + 1, 0, 1, 0);
    pin_iss("held c2", OFF + 2, 0, 1, 0);
    pin_iss("held c3", OFF + 3, 2, 3, 0);
    chk("held done c20", g_done[OFF + 20], 1);
    chk("held idle c21", g_busy[OFF + 21], 0);
    pin_iss("held restart", OFF + 22, 0, 1, 0);

    // 16-point, BF_LAT=1
    clear_in();
    in_start[OFF] = 1'b1;
    run(1, 4, 1, OFF + 40, "n16");
    chk("n16 issue count", count_valid(OFF + 40), 32);
    last = 0;
    for (int t = 0; t < OFF + 40; t++) if (g_v[t] == 1) last = t;
    pin_iss("n16 last", last, 7, 15, 7);
    pin_done("n16", OFF + 37, OFF + 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_seq.md
FFT_SEQ -- requirements
Module: fft_seq

Interface
REQ-001 Parameter N_LOG2, default 3: FFT size N = 2^N_LOG2 points. Legal values are 2..6.
REQ-002 Parameter BF_LAT, default 2: datapath butterfly latency in cycles, used as the gap/drain length. Legal values are 1..7.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 start  input  1  request one full transform; sampled only in IDLE.
REQ-006 stall  input  1  datapath back-pressure; while high, the sequencer state is frozen.
REQ-007 busy  output  1  transform in progress.
REQ-008 done  output  1  one-cycle pulse when the transform completes.
REQ-009 bf_valid  output  1  a butterfly is issued on addr_a/addr_b/tw_idx.
REQ-010 addr_a  output  N_LOG2  upper butterfly operand address.
REQ-011 addr_b  output  N_LOG2  lower butterfly operand address.
REQ-012 tw_idx  output  N_LOG2-1  twiddle index into W_N^tw_idx.
REQ-013 stage  output  ceil(log2(N_LOG2))  current stage number, 0..N_LOG2-1.

Function
REQ-014 The block has four states, IDLE, ISSUE, GAP and DONE, with the following transitions:
- IDLE -> ISSUE when start is high.
- ISSUE -> GAP after the last butterfly of a stage.
- GAP -> ISSUE after BF_LAT cycles if stages remain.
- GAP -> DONE after BF_LAT cycles if the final stage is finished (final drain).
- DONE -> IDLE unconditionally.
REQ-015 Each stage s issues N/2 butterflies, k = 0..N/2-1 in ascending order, one per non-stalled cycle.
REQ-016 Butterfly address arithmetic:
- span = 2^s
- pos = k mod span
- group = k div span
- addr_a = group*2*span + pos
- addr_b = addr_a + span
- tw_idx = pos << (N_LOG2-1-s)
- All results are unsigned and fit their port widths without overflow.
REQ-017 bf_valid is high only in ISSUE.
REQ-018 When bf_valid is low, addr_a, addr_b and tw_idx are 0.
REQ-019 stage is held through GAP and reads 0 in IDLE.
REQ-020 stall high in any state other than IDLE freezes all of the following, with outputs held stable:
- the state
- k
- s
- the gap counter
REQ-021 An issue presented with bf_valid high while stall is high is consumed only in the first cycle in which stall is low.
REQ-022 busy is high in ISSUE and GAP, and low in IDLE and DONE.
REQ-023 done is high only in DONE, for exactly one cycle.
REQ-024 start sampled in any state other than IDLE is ignored, with no queuing.
REQ-025 start held high continuously causes a new transform to begin on the first cycle back in IDLE.
REQ-026 Latency with no stall: the first bf_valid occurs in the cycle after start is sampled; done occurs N_LOG2*(N/2 + BF_LAT) + 1 cycles after start is sampled.
REQ-027 stall asserted in IDLE has no effect.
REQ-028 start and stall both high in IDLE: the block enters ISSUE, and the first issue is then held while stall remains high.

Reset
REQ-029 rst_n low at a rising edge forces IDLE, with k = 0, s = 0 and gap counter = 0.
REQ-030 While rst_n is low, busy = 0, done = 0 and bf_valid = 0.
REQ-031 While rst_n is low, addr_a = 0, addr_b = 0, tw_idx = 0 and stage = 0.
REQ-032 Reset asserted mid-transform aborts it with no done pulse.
REQ-033 After rst_n returns high, the block waits in IDLE for a fresh start.
REQ-034 Reset takes priority over start and stall.

Verification
REQ-035 Defaults, start pulse at cycle 0, no stall -> all of the following:
- bf_valid in cycles 1-4, 7-10 and 13-16.
- Cycle 1 shows (a,b,tw) = (0,1,0).
- Cycle 8 shows (1,3,2).
- Cycle 16 shows (3,7,3).
- done high in cycle 19 only.
- busy high in cycles 1-18.
REQ-036 Defaults, full address trace -> exactly 12 issues, in this order:
- Stage 0: (0,1), (2,3), (4,5), (6,7), all with tw 0.
- Stage 1: (0,2,0), (1,3,2), (4,6,0), (5,7,2).
- Stage 2: (0,4,0), (1,5,1), (2,6,2), (3,7,3).
REQ-037 stall high for cycles 2-4 -> outputs frozen at the second issue, (2,3,0), through cycle 5; all later events shift by 3 cycles; done in cycle 22.
REQ-038 rst_n low in cycle 9 -> in cycle 10: bf_valid=0, busy=0, all addresses 0; no done pulse follows; a subsequent start reproduces the REQ-035 trace.
REQ-039 start re-pulsed in cycles 5 and 12 -> ignored; the trace is identical to REQ-035.
REQ-040 N_LOG2=4, BF_LAT=1 -> 32 issues; last issue is (7,15,7); done 4*(8+1)+1 = 37 cycles after start.
